// File: rtl/edge_stim_gen_if.sv
// Control, timing-config and stimulus-output bundle for edge_stim_gen.
// The master side issues requests and config; the slave side drives the stimulus pins.
interface edge_stim_gen_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic          start;
    logic          abort;
    logic [W-1:0]  data_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_w;
    logic [CW-1:0] setup_t;
    logic [CW-1:0] hold_t;
    logic          data_o;
    logic          strobe_o;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        output start, abort, data_in, period, high_w, setup_t, hold_t,
        input  data_o, strobe_o, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, data_in, period, high_w, setup_t, hold_t,
        output data_o, strobe_o, busy, done, cfg_err
    );
endinterface

// File: rtl/edge_stim_gen.sv
// Serializes a W-bit word MSB first and emits a strobe, with setup/hold/width/period
// programmed per transaction in clk ticks. All outputs are registered.
module edge_stim_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input logic            clk,
    input logic            clr,
    edge_stim_gen_if.slave bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] t, t_n;
    logic [IW-1:0] idx, idx_n;
    logic [W-1:0]  word, word_n;
    logic [CW-1:0] per_q, per_n, hw_q, hw_n, su_q, su_n, ho_q, ho_n;
    logic          data_n, strobe_n, busy_n, done_n, err_n;
    logic          cfg_ok;
    logic [CW:0]   su_hw_n, su_ho_n;

    // Sums are one bit wider than the fields so large values cannot wrap into range.
    assign cfg_ok = (bus.period >= CW'(2)) && (bus.high_w != '0) && (bus.setup_t != '0)
                 && (({1'b0, bus.setup_t} + {1'b0, bus.high_w}) <= {1'b0, bus.period})
                 && (({1'b0, bus.setup_t} + {1'b0, bus.hold_t})
                     <= ({1'b0, bus.period} - (CW+1)'(1)));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_n = state;
        t_n     = t;
        idx_n   = idx;
        word_n  = word;
        per_n   = per_q;
        hw_n    = hw_q;
        su_n    = su_q;
        ho_n    = ho_q;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        state_n = RUN;
                        t_n     = '0;
                        idx_n   = IW'(W - 1);
                        word_n  = bus.data_in;
                        per_n   = bus.period;
                        hw_n    = bus.high_w;
                        su_n    = bus.setup_t;
                        ho_n    = bus.hold_t;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (t == per_q - CW'(1)) begin
                    t_n = '0;
                    if (idx == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx - IW'(1);
                    end
                end else begin
                    t_n = t + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from next-state values so the registered pins line up with t.
        su_hw_n  = {1'b0, su_n} + {1'b0, hw_n};
        su_ho_n  = {1'b0, su_n} + {1'b0, ho_n};
        busy_n   = (state_n == RUN);
        data_n   = busy_n && ({1'b0, t_n} <= su_ho_n) && word_n[idx_n];
        strobe_n = busy_n && (t_n >= su_n) && ({1'b0, t_n} < su_hw_n);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            t            <= '0;
            idx          <= '0;
            word         <= '0;
            per_q        <= '0;
            hw_q         <= '0;
            su_q         <= '0;
            ho_q         <= '0;
            bus.data_o   <= 1'b0;
            bus.strobe_o <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.cfg_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_n;
            t            <= t_n;
            idx          <= idx_n;
            word         <= word_n;
            per_q        <= per_n;
            hw_q         <= hw_n;
            su_q         <= su_n;
            ho_q         <= ho_n;
            bus.data_o   <= data_n;
            bus.strobe_o <= strobe_n;
            bus.busy     <= busy_n;
            bus.done     <= done_n;
            bus.cfg_err  <= err_n;
        end
    end
endmodule

// File: tb/tb_edge_stim_gen.sv
// Randomized bench for edge_stim_gen: a frame-level reference model fills a per-cycle
// expectation queue and a negedge monitor pops and compares it against the DUT pins.
module tb_edge_stim_gen;
    localparam int W  = 8;
    localparam int CW = 8;

    typedef struct packed {
        logic busy;
        logic data;
        logic strobe;
        logic done;
        logic cfg_err;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    edge_stim_gen_if #(.W(W), .CW(CW)) bus ();

    edge_stim_gen #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h (bits busy,data,strobe,done,cfg_err)",
                     name, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] pins();
        exp_t a;
        a = {bus.busy, bus.data_o, bus.strobe_o, bus.done, bus.cfg_err};
        return {27'b0, a};
    endfunction

    // Whole-transaction waveform built frame by frame from the timing rules.
    function automatic void push_txn(input logic [W-1:0] d, input int p, input int hw,
                                     input int s, input int h);
        exp_t e;
        for (int f = 0; f < W; f++) begin
            for (int tk = 0; tk < p; tk++) begin
                e        = '0;
                e.busy   = 1'b1;
                e.data   = (tk <= s + h) ? d[W-1-f] : 1'b0;
                e.strobe = (tk >= s) && (tk < s + hw);
                exp_q.push_back(e);
            end
        end
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Queue front always describes the current cycle; the model acts on this cycle's inputs.
    function automatic void model(input bit st, input bit ab, input logic [W-1:0] d,
                                  input int p, input int hw, input int s, input int h);
        exp_t e;
        bit   idle_now;
        if (exp_q.size() == 0) begin
            e = '0;
            exp_q.push_back(e);
        end
        idle_now = !exp_q[0].busy;
        if (idle_now && st) begin
            if (p >= 2 && hw >= 1 && s >= 1 && s + hw <= p && s + h <= p - 1) begin
                push_txn(d, p, hw, s, h);
            end else begin
                e         = '0;
                e.cfg_err = 1'b1;
                exp_q.push_back(e);
            end
        end else if (!idle_now && ab) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        end
    endfunction

    task automatic step(input bit st, input bit ab, input logic [W-1:0] d,
                        input int p, input int hw, input int s, input int h);
        bus.start   = st;
        bus.abort   = ab;
        bus.data_in = d;
        bus.period  = CW'(p);
        bus.high_w  = CW'(hw);
        bus.setup_t = CW'(s);
        bus.hold_t  = CW'(h);
        model(st, ab, d, p, hw, s, h);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with scrambled config on the inputs, which must not disturb a running frame.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, W'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic do_clr();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #2 clr = 1'b1;
        exp_q.delete();
        #1 check("clr_async", pins(), 32'd0);
        #4 clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '0;
            check("mon", pins(), {27'b0, e});
        end
    end

    initial begin
        int p, hw, s, h, n;
        clr         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.data_in = '0;
        bus.period  = '0;
        bus.high_w  = '0;
        bus.setup_t = '0;
        bus.hold_t  = '0;
        repeat (3) @(posedge clk);
        #1 check("reset", pins(), 32'd0);
        #2 clr = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // 0xA5 frame train; RUN starts ignored; start held through the done cycle re-triggers.
        step(1'b1, 1'b0, 8'hA5, 10, 4, 3, 2);
        for (int i = 1; i <= 81; i++) begin
            if (i == 81) step(1'b1, 1'b0, 8'h5A, 10, 4, 3, 2);
            else step(i == 5 || i == 30 || i == 80, 1'b0, W'($urandom), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        idle(85);

        // Rejected configs, including a sum that would alias at CW bits.
        step(1'b1, 1'b0, 8'hFF, 5, 3, 3, 0);
        idle(2);
        step(1'b1, 1'b0, 8'hFF, 5, 1, 3, 2);
        idle(2);
        step(1'b1, 1'b0, 8'hFF, 255, 100, 200, 0);
        step(1'b0, 1'b0, 8'hFF, 1, 1, 1, 0);
        step(1'b1, 1'b0, 8'hFF, 1, 1, 1, 0);
        step(1'b1, 1'b0, 8'hFF, 8, 0, 1, 0);
        step(1'b1, 1'b0, 8'hFF, 8, 1, 0, 0);
        idle(3);

        // Abort mid-run, then a clean 0x3C transaction; start+abort in IDLE is a start.
        step(1'b1, 1'b0, 8'hC3, 10, 4, 3, 2);
        idle(24);
        step(1'b0, 1'b1, 8'h00, 10, 4, 3, 2);
        idle(3);
        step(1'b1, 1'b1, 8'h3C, 10, 4, 3, 2);
        idle(85);

        // Asynchronous clear mid-transaction, then a normal run.
        step(1'b1, 1'b0, 8'h96, 10, 4, 3, 2);
        idle(39);
        do_clr();
        step(1'b1, 1'b0, 8'h69, 10, 4, 3, 2);
        idle(85);

        // Minimal legal config.
        step(1'b1, 1'b0, 8'hFF, 2, 1, 1, 0);
        idle(20);

        // Randomized transactions with sporadic starts and aborts.
        for (int k = 0; k < 40; k++) begin
            p  = $urandom_range(0, 9);
            hw = $urandom_range(0, 5);
            s  = $urandom_range(0, 6);
            h  = $urandom_range(0, 6);
            step(1'b1, $urandom_range(0, 3) == 0, W'($urandom), p, hw, s, h);
            n = $urandom_range(0, 90);
            for (int i = 0; i < n; i++) begin
                p  = $urandom_range(0, 9);
                hw = $urandom_range(0, 5);
                s  = $urandom_range(0, 6);
                h  = $urandom_range(0, 6);
                step($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, W'($urandom),
                     p, hw, s, h);
            end
        end
        idle(100);
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
